// File: rtl/had_regacc_pkg.sv
// Shared types and defaults for the HAD register-file access arbiter.
// Optional timeout feature: define HAD_REGACC_TIMEOUT_EN.
package had_regacc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_e;

  localparam logic REQ_JT  = 1'b0;
  localparam logic REQ_SYS = 1'b1;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/had_regacc_rr.sv
// Two-way round-robin picker; grant bit 0 is JTAG, bit 1 is system.
// last_grant is only updated when a transaction completes.
module had_regacc_rr
  import had_regacc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       upd_id_i,
  output logic [1:0] grant_o
);

  logic last_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= REQ_SYS;
    end else if (update_i) begin
      last_q <= upd_id_i;
    end
  end

  always_comb begin
    grant_o = 2'b00;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_q == REQ_SYS) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/had_regacc_arb.sv
// HAD register-file port arbiter/sequencer (JTAG vs system requester).
// Optional ISSUE timeout: define HAD_REGACC_TIMEOUT_EN.
module had_regacc_arb
  import had_regacc_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              forever_cpuclk_nogated,
  input  logic              hadrst,
  input  logic              jt_req,
  input  logic              jt_wr,
  input  logic [ADDR_W-1:0] jt_addr,
  input  logic [DATA_W-1:0] jt_wdata,
  output logic              jt_ack,
  input  logic              sys_req,
  input  logic              sys_wr,
  input  logic [ADDR_W-1:0] sys_addr,
  input  logic [DATA_W-1:0] sys_wdata,
  output logic              sys_ack,
  output logic [DATA_W-1:0] ack_rdata,
  output logic              ack_err,
  output logic              rf_sel,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  input  logic              rf_rdy,
  output logic              arb_busy
);

  state_e            state_q;
  logic              owner_q;
  logic              jt_ack_q;
  logic              sys_ack_q;
  logic              busy_q;
  logic              rf_sel_q;
  logic              rf_wr_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic [DATA_W-1:0] ack_rdata_q;
  logic [1:0]        grant;

  had_regacc_rr u_rr (
    .clk_i    (forever_cpuclk_nogated),
    .rst_i    (hadrst),
    .req_i    ({sys_req, jt_req}),
    .update_i (state_q == S_DONE),
    .upd_id_i (owner_q),
    .grant_o  (grant)
  );

`ifdef HAD_REGACC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
`endif

  // rf_* registers double as the command register; cleared outside ISSUE
  always_ff @(posedge forever_cpuclk_nogated or posedge hadrst) begin
    if (hadrst) begin
      state_q     <= S_IDLE;
      owner_q     <= REQ_JT;
      jt_ack_q    <= 1'b0;
      sys_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      rf_sel_q    <= 1'b0;
      rf_wr_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_wdata_q  <= '0;
      ack_rdata_q <= '0;
`ifdef HAD_REGACC_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      jt_ack_q  <= 1'b0;
      sys_ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (|grant) begin
            owner_q    <= grant[1];
            rf_sel_q   <= 1'b1;
            rf_wr_q    <= grant[1] ? sys_wr : jt_wr;
            rf_addr_q  <= grant[1] ? sys_addr : jt_addr;
            rf_wdata_q <= grant[1] ? sys_wdata : jt_wdata;
            busy_q     <= 1'b1;
`ifdef HAD_REGACC_TIMEOUT_EN
            cnt_q      <= CNT_W'(TIMEOUT);
`endif
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (rf_rdy) begin
            rf_sel_q    <= 1'b0;
            rf_wr_q     <= 1'b0;
            rf_addr_q   <= '0;
            rf_wdata_q  <= '0;
            ack_rdata_q <= rf_wr_q ? '0 : rf_rdata;
            jt_ack_q    <= (owner_q == REQ_JT);
            sys_ack_q   <= (owner_q == REQ_SYS);
            state_q     <= S_DONE;
`ifdef HAD_REGACC_TIMEOUT_EN
            err_q       <= 1'b0;
          end else if (cnt_q == CNT_W'(1)) begin
            rf_sel_q    <= 1'b0;
            rf_wr_q     <= 1'b0;
            rf_addr_q   <= '0;
            rf_wdata_q  <= '0;
            ack_rdata_q <= '0;
            err_q       <= 1'b1;
            jt_ack_q    <= (owner_q == REQ_JT);
            sys_ack_q   <= (owner_q == REQ_SYS);
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
`endif
          end
        end
        S_DONE: begin
          ack_rdata_q <= '0;
`ifdef HAD_REGACC_TIMEOUT_EN
          err_q       <= 1'b0;
`endif
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign jt_ack    = jt_ack_q;
  assign sys_ack   = sys_ack_q;
  assign ack_rdata = ack_rdata_q;
  assign rf_sel    = rf_sel_q;
  assign rf_wr     = rf_wr_q;
  assign rf_addr   = rf_addr_q;
  assign rf_wdata  = rf_wdata_q;
  assign arb_busy  = busy_q;
`ifdef HAD_REGACC_TIMEOUT_EN
  assign ack_err   = err_q;
`else
  assign ack_err   = 1'b0;
`endif

endmodule

// File: tb/tb_had_regacc_arb.sv
// Randomized bench for had_regacc_arb against a transaction-level model.
// Timeout cases run only when HAD_REGACC_TIMEOUT_EN is defined.
module tb_had_regacc_arb;
  import had_regacc_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          jt_req = 0, jt_wr = 0;
  logic [AW-1:0] jt_addr = '0;
  logic [DW-1:0] jt_wdata = '0;
  logic          sys_req = 0, sys_wr = 0;
  logic [AW-1:0] sys_addr = '0;
  logic [DW-1:0] sys_wdata = '0;
  logic [DW-1:0] rf_rdata = '0;
  logic          rf_rdy = 1'b0;
  logic          jt_ack, sys_ack, ack_err;
  logic          rf_sel, rf_wr, arb_busy;
  logic [DW-1:0] ack_rdata, rf_wdata;
  logic [AW-1:0] rf_addr;

  always #5 clk = ~clk;

  had_regacc_arb #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .forever_cpuclk_nogated(clk),
    .hadrst   (rst),
    .jt_req   (jt_req),
    .jt_wr    (jt_wr),
    .jt_addr  (jt_addr),
    .jt_wdata (jt_wdata),
    .jt_ack   (jt_ack),
    .sys_req  (sys_req),
    .sys_wr   (sys_wr),
    .sys_addr (sys_addr),
    .sys_wdata(sys_wdata),
    .sys_ack  (sys_ack),
    .ack_rdata(ack_rdata),
    .ack_err  (ack_err),
    .rf_sel   (rf_sel),
    .rf_wr    (rf_wr),
    .rf_addr  (rf_addr),
    .rf_wdata (rf_wdata),
    .rf_rdata (rf_rdata),
    .rf_rdy   (rf_rdy),
    .arb_busy (arb_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // requester model: index 0 = JTAG, 1 = system
  bit            r_req [2];
  logic          r_wr  [2];
  logic [AW-1:0] r_addr[2];
  logic [DW-1:0] r_wd  [2];
  bit            last_m;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive();
    jt_req    = r_req[0];
    jt_wr     = r_wr[0];
    jt_addr   = r_addr[0];
    jt_wdata  = r_wd[0];
    sys_req   = r_req[1];
    sys_wr    = r_wr[1];
    sys_addr  = r_addr[1];
    sys_wdata = r_wd[1];
  endtask

  task automatic new_cmd(input int r);
    r_req[r]  = 1'b1;
    r_wr[r]   = 1'($urandom_range(0, 1));
    r_addr[r] = AW'($urandom);
    r_wd[r]   = $urandom;
  endtask

  task automatic quiet(input string tag);
    check({tag, "_ctl"},
          {58'd0, jt_ack, sys_ack, ack_err, rf_sel, rf_wr, arb_busy}, 64'd0);
    check({tag, "_rdat"}, {32'd0, ack_rdata}, 64'd0);
    check({tag, "_cmd"}, {24'd0, rf_addr, rf_wdata}, 64'd0);
  endtask

  // Called at the negedge of an IDLE cycle with requests already applied.
  task automatic serve(input int force_lat, input bit keep,
                       input bit fix, input logic [DW-1:0] fixv);
    bit            w, to;
    int            lat, nsel;
    logic [DW-1:0] rd, rnow, exp_rd;
    check("idle_busy", {63'd0, arb_busy}, 64'd0);
    check("idle_sel", {63'd0, rf_sel}, 64'd0);
    rf_rdy = 1'($urandom_range(0, 1));
    w = (r_req[0] && r_req[1]) ? ~last_m : r_req[1];
    lat = (force_lat != 0) ? force_lat : $urandom_range(1, 6);
    to = 1'b0;
`ifdef HAD_REGACC_TIMEOUT_EN
    if (lat > TO) to = 1'b1;
`endif
    nsel = to ? TO : lat;
    rd = '0;
    tick();
    for (int k = 1; k <= nsel; k++) begin
      check("iss_sel", {63'd0, rf_sel}, 64'd1);
      check("iss_busy", {63'd0, arb_busy}, 64'd1);
      check("iss_cmd", {23'd0, rf_wr, rf_addr, rf_wdata},
            {23'd0, r_wr[w], r_addr[w], r_wd[w]});
      check("iss_ack", {62'd0, jt_ack, sys_ack}, 64'd0);
      rf_rdy = (!to && k == lat);
      rnow = fix ? fixv : $urandom;
      rf_rdata = rnow;
      if (rf_rdy) rd = rnow;
      tick();
    end
    rf_rdy = 1'b0;
    rf_rdata = $urandom;
    exp_rd = (to || r_wr[w]) ? '0 : rd;
    check("ack_who", {62'd0, jt_ack, sys_ack},
          w ? 64'd1 : 64'd2);
    check("ack_rdata", {32'd0, ack_rdata}, {32'd0, exp_rd});
    check("ack_err", {63'd0, ack_err}, {63'd0, to});
    check("done_sel", {63'd0, rf_sel}, 64'd0);
    check("done_busy", {63'd0, arb_busy}, 64'd1);
    if (!keep) r_req[w] = 1'b0;
    drive();
    last_m = w;
    tick();
  endtask

  initial begin
    r_req = '{0, 0};
    r_wr = '{0, 0};
    r_addr = '{0, 0};
    r_wd = '{0, 0};
    last_m = REQ_SYS;
    drive();
    #1;
    quiet("reset");
    tick();
    rst = 1'b0;

    // JTAG read, minimum latency
    r_req[0] = 1; r_wr[0] = 0; r_addr[0] = 8'h10; r_wd[0] = '0;
    drive();
    serve(1, 0, 1, 32'h1234_5678);

    // simultaneous contests
    new_cmd(0); new_cmd(1); drive();
    serve(0, 0, 0, '0);
    serve(0, 0, 0, '0);
    new_cmd(0); new_cmd(1); drive();
    serve(0, 0, 0, '0);
    serve(0, 0, 0, '0);

    // SYS write, 5-cycle latency
    r_req[1] = 1; r_wr[1] = 1; r_addr[1] = 8'h22; r_wd[1] = 32'hA5A5_0001;
    drive();
    serve(5, 0, 0, '0);

    // stray rf_rdy while idle, then back-to-back from a held request
    rf_rdy = 1'b1;
    tick();
    rf_rdy = 1'b0;
    quiet("stray");
    new_cmd(0); drive();
    serve(0, 1, 0, '0);
    serve(0, 0, 0, '0);

    // reset during ISSUE after a JTAG grant
    new_cmd(0); drive();
    serve(0, 0, 0, '0);
    new_cmd(0); drive();
    tick();
    check("pre_rst_sel", {63'd0, rf_sel}, 64'd1);
    rst = 1'b1;
    #1;
    quiet("rst_mid");
    r_req[0] = 0; drive();
    tick();
    rst = 1'b0;
    last_m = REQ_SYS;
    repeat (3) begin
      tick();
      quiet("post_rst");
    end
    new_cmd(0); new_cmd(1); drive();
    serve(0, 0, 0, '0);
    serve(0, 0, 0, '0);

`ifdef HAD_REGACC_TIMEOUT_EN
    r_req[0] = 1; r_wr[0] = 0; r_addr[0] = 8'h33; drive();
    serve(TO + 1, 0, 0, '0);
    r_req[1] = 1; r_wr[1] = 0; r_addr[1] = 8'h44; drive();
    serve(TO, 0, 0, '0);
`endif

    for (int it = 0; it < 40; it++) begin
      int sel, guard;
      sel = $urandom_range(1, 3);
      if (sel[0]) new_cmd(0);
      if (sel[1]) new_cmd(1);
      drive();
      guard = 0;
      while ((r_req[0] || r_req[1]) && guard < 4) begin
        serve(0, (guard < 2) && ($urandom_range(0, 3) == 0), 0, '0);
        guard++;
      end
      if (r_req[0] || r_req[1]) begin
        r_req = '{0, 0};
        drive();
        tick();
        quiet("drain");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
